// File: rtl/vga_plot_ctrl.sv
// Plot scheduler for the vga framebuffer writer: queues single-pixel plot
// requests in a small FIFO and runs a full-screen clear sweep with priority.
module vga_plot_ctrl #(
  parameter int XMAX  = 160,
  parameter int YMAX  = 120,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  input  logic       clr_start,
  input  logic [2:0] clr_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       clr_done,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_req_d, r_clr_d;
  logic [17:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count;
  logic [7:0]     r_cx;
  logic [6:0]     r_cy;
  logic [2:0]     r_clr_col;
  logic           r_done_pend;

  logic w_req_rise, w_clr_cap, w_full, w_empty, w_push, w_pop, w_last;

  assign w_req_rise = req_valid & ~r_req_d;
  assign w_clr_cap  = clr_start & ~r_clr_d & (r_state != S_CLEAR);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  // Full check uses the pre-pop count, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign w_push     = w_req_rise & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_clr_cap & ~w_empty;
  assign w_last     = (r_cx == 8'(XMAX-1)) && (r_cy == 7'(YMAX-1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_clr_cap) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_last)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_x, req_y, req_colour};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req_d     <= 1'b0;
      r_clr_d     <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_clr_col   <= '0;
      r_done_pend <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      clr_done    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_d     <= req_valid;
      r_clr_d     <= clr_start;
      plot        <= 1'b0;
      clr_done    <= r_done_pend;
      r_done_pend <= 1'b0;
      busy        <= (r_state == S_CLEAR) | ~w_empty;

      if (w_req_rise & w_full) overflow <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_clr_cap) begin
            r_cx      <= '0;
            r_cy      <= '0;
            r_clr_col <= clr_colour;
          end else if (w_pop) begin
            plot                <= 1'b1;
            {x, y, colour}      <= r_mem[r_rd_ptr];
          end
        end
        S_CLEAR: begin
          plot   <= 1'b1;
          x      <= r_cx;
          y      <= r_cy;
          colour <= r_clr_col;
          if (r_cx == 8'(XMAX-1)) begin
            r_cx <= '0;
            r_cy <= r_cy + 1'b1;
          end else begin
            r_cx <= r_cx + 1'b1;
          end
          if (w_last) r_done_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_ctrl.sv
// Scoreboard bench for vga_plot_ctrl: a transaction-level model predicts the
// pixel stream and status flags; a negedge monitor compares against the DUT.
module tb_vga_plot_ctrl;

  localparam int XMAX  = 160;
  localparam int YMAX  = 120;
  localparam int DEPTH = 4;
  localparam int NPIX  = XMAX * YMAX;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [2:0] req_colour = '0;
  logic       clr_start = 1'b0;
  logic [2:0] clr_colour = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, clr_done, overflow;

  vga_plot_ctrl #(.XMAX(XMAX), .YMAX(YMAX), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .clr_start(clr_start), .clr_colour(clr_colour),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .clr_done(clr_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int plot_cnt = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep as a pixel index, FIFO as a bounded queue.
  logic [17:0] exp_q[$];
  logic [17:0] m_fifo[$];
  int   m_idx = -1;
  logic [2:0] m_ccol = '0;
  bit   m_prev_req = 0, m_prev_clr = 0;
  bit   m_plot = 0, m_done = 0, m_done_pend = 0, m_busy = 0, m_ovf = 0;
  bit   m_rise, m_crise;
  int   m_pre;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_fifo.delete();
      m_idx = -1;
      m_prev_req = 0; m_prev_clr = 0;
      m_plot = 0; m_done = 0; m_done_pend = 0; m_busy = 0; m_ovf = 0;
    end else begin
      m_rise  = req_valid && !m_prev_req;
      m_crise = clr_start && !m_prev_clr && (m_idx < 0);
      m_pre   = m_fifo.size();
      m_busy  = (m_idx >= 0) || (m_pre != 0);
      m_done  = m_done_pend;
      m_done_pend = 0;
      m_plot  = 0;
      if (m_idx >= 0) begin
        exp_q.push_back({8'(m_idx % XMAX), 7'(m_idx / XMAX), m_ccol});
        m_plot = 1;
        m_idx++;
        if (m_idx == NPIX) begin
          m_idx = -1;
          m_done_pend = 1;
        end
      end else if (m_crise) begin
        m_idx  = 0;
        m_ccol = clr_colour;
      end else if (m_pre != 0) begin
        exp_q.push_back(m_fifo.pop_front());
        m_plot = 1;
      end
      if (m_rise) begin
        if (m_pre == DEPTH) m_ovf = 1;
        else m_fifo.push_back({req_x, req_y, req_colour});
      end
      m_prev_req = req_valid;
      m_prev_clr = clr_start;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("plot", plot, m_plot);
      if (plot) begin
        check("scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("pixel", {x, y, colour}, exp_q.pop_front());
      end
      check("clr_done", clr_done, m_done);
      check("busy", busy, m_busy);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (plot) plot_cnt++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_clr(input logic [2:0] col);
    clr_colour = col;
    clr_start  = 1'b1;
    tick(1);
    clr_start  = 1'b0;
  endtask

  task automatic wait_clr_done();
    bit seen = 0;
    for (int i = 0; i < NPIX + 1000; i++) begin
      @(negedge clk);
      if (plot) plot_cnt++;
      if (clr_done) begin
        seen = 1;
        break;
      end
    end
    check("clr_done_timeout", seen, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic send_req(input logic [7:0] rx, input logic [6:0] ry, input logic [2:0] rc);
    req_x = rx; req_y = ry; req_colour = rc;
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(1);
  endtask

  int c0;

  initial begin
    // Level held through reset release: one capture only.
    req_valid = 1'b1; req_x = 8'd7; req_y = 7'd9; req_colour = 3'd2;
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    tick(2);
    check("reset_plot", plot, 0);
    check("reset_xyc", {x, y, colour}, 0);
    reset = 1'b0;
    tick(6);
    req_valid = 1'b0;
    tick(2);
    check("level_hold_count", plot_cnt, 1);

    // Single request: plot exactly once, two edges after the rise.
    c0 = plot_cnt;
    req_x = 8'd10; req_y = 7'd20; req_colour = 3'd5;
    req_valid = 1'b1;
    tick(1);
    check("single_lat_k", plot, 0);
    tick(1);
    check("single_lat_k1", plot, 1);
    check("single_pixel", {x, y, colour}, {8'd10, 7'd20, 3'd5});
    tick(8);
    req_valid = 1'b0;
    tick(2);
    check("single_count", plot_cnt - c0, 1);
    check("single_hold", {x, y, colour}, {8'd10, 7'd20, 3'd5});

    // Full clear sweep.
    c0 = plot_cnt;
    pulse_clr(3'd3);
    wait_clr_done();
    check("sweep_count", plot_cnt - c0, NPIX);
    check("sweep_busy_after", busy, 0);
    check("sweep_done_width", clr_done, 0);

    // Overflow: 6 request edges during a sweep.
    pulse_clr(3'($urandom_range(0, 7)));
    tick(5);
    for (int i = 0; i < 6; i++) begin
      req_x = 8'($urandom_range(0, 159)); req_y = 7'($urandom_range(0, 119));
      req_colour = 3'($urandom_range(0, 7));
      req_valid = 1'b1;
      tick(1);
      if (i == 3) check("overflow_before_5th", overflow, 0);
      if (i == 4) check("overflow_at_5th", overflow, 1);
      req_valid = 1'b0;
      tick(1);
    end
    wait_clr_done();
    tick(10);

    // Simultaneous request + clear, then a mid-sweep clear edge to ignore.
    c0 = plot_cnt;
    req_x = 8'd1; req_y = 7'd1; req_colour = 3'd6;
    req_valid = 1'b1;
    pulse_clr(3'd4);
    req_valid = 1'b0;
    tick(1000);
    pulse_clr(3'd1);
    wait_clr_done();
    check("simul_count", plot_cnt - c0, NPIX + 1);
    check("simul_req_last", {x, y, colour}, {8'd1, 7'd1, 3'd6});
    tick(5);

    // Reset mid-sweep with two requests queued.
    pulse_clr(3'd2);
    send_req(8'd33, 7'd44, 3'd5);
    send_req(8'd55, 7'd66, 3'd7);
    tick(495);
    reset = 1'b1;
    #1;
    check("midreset_plot", plot, 0);
    check("midreset_xyc", {x, y, colour}, 0);
    check("midreset_flags", {busy, clr_done, overflow}, 0);
    tick(3);
    reset = 1'b0;
    c0 = plot_cnt;
    tick(60);
    check("midreset_no_plot", plot_cnt - c0, 0);

    // Randomized request traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_x      = 8'($urandom_range(0, 255));
      req_y      = 7'($urandom_range(0, 127));
      req_colour = 3'($urandom_range(0, 7));
      tick(1);
    end
    req_valid = 1'b0;

    begin
      bit idle = 0;
      for (int i = 0; i < 200; i++) begin
        tick(1);
        if (!busy && m_fifo.size() == 0 && m_idx < 0) begin
          idle = 1;
          break;
        end
      end
      check("drain_timeout", idle, 1);
    end
    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
